// File: rtl/qm_icache_dm_if.sv
// Fetch-to-icache lookup bundle plus the icache refill memory port.
// master = fetch stage / memory side, slave = the cache.
interface qm_icache_dm_if;
    logic        enable;
    logic [31:0] address;
    logic [31:0] data;
    logic        hit;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output enable, address, mem_ack, mem_rdata,
        input  data, hit, stall, mem_req, mem_addr
    );

    modport slave (
        input  enable, address, mem_ack, mem_rdata,
        output data, hit, stall, mem_req, mem_addr
    );
endinterface

// File: rtl/qm_icache_dm.sv
// Direct-mapped read-only icache with a req/ack line-refill FSM.
// Optional hit/miss counters under QM_ICACHE_STATS_EN.
module qm_icache_dm #(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic clk,
    input  logic reset,
`ifdef QM_ICACHE_STATS_EN
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses,
`endif
    qm_icache_dm_if.slave bus
);
    localparam int OFF = $clog2(LINE_WORDS);
    localparam int IDX = $clog2(LINES);
    localparam int TAG = 30 - IDX - OFF;
    localparam logic [OFF-1:0] LAST = OFF'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMMIT
    } state_t;

    state_t state, next_state;

    logic [OFF-1:0] a_off;
    logic [IDX-1:0] a_idx;
    logic [TAG-1:0] a_tag;
    logic           unused_bits;

    logic [LINES-1:0] valid;
    logic [TAG-1:0]   tag_mem  [LINES];
    logic [31:0]      data_mem [LINES][LINE_WORDS];

    logic [IDX-1:0] f_idx;
    logic [TAG-1:0] f_tag;
    logic [OFF-1:0] beat;

    logic        lookup_hit;
    logic        hit_c;
    logic        stall_c;
    logic        miss_go;
    logic        req_c;
    logic [31:0] maddr_c;

    assign a_off = bus.address[OFF+1:2];
    assign a_idx = bus.address[OFF+IDX+1:OFF+2];
    assign a_tag = bus.address[31:OFF+IDX+2];
    assign unused_bits = ^bus.address[1:0];

    assign lookup_hit = valid[a_idx] && (tag_mem[a_idx] == a_tag);

    always_comb begin
        next_state = state;
        hit_c      = 1'b0;
        stall_c    = 1'b0;
        miss_go    = 1'b0;
        req_c      = 1'b0;
        maddr_c    = '0;
        unique case (state)
            IDLE: begin
                hit_c   = bus.enable & lookup_hit;
                miss_go = bus.enable & ~lookup_hit;
                stall_c = miss_go;
                if (miss_go) next_state = FILL;
            end
            FILL: begin
                stall_c = bus.enable;
                req_c   = 1'b1;
                maddr_c = {f_tag, f_idx, beat, 2'b00};
                if (bus.mem_ack && beat == LAST) next_state = COMMIT;
            end
            COMMIT: begin
                stall_c    = bus.enable;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // Fetch sees a quiet cache while reset is held.
        if (reset) begin
            hit_c   = 1'b0;
            stall_c = 1'b0;
            miss_go = 1'b0;
        end
    end

    assign bus.hit      = hit_c;
    assign bus.stall    = stall_c;
    assign bus.data     = data_mem[a_idx][a_off];
    assign bus.mem_req  = req_c;
    assign bus.mem_addr = maddr_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            valid <= '0;
            f_idx <= '0;
            f_tag <= '0;
            beat  <= '0;
        end else begin
            state <= next_state;
            if (miss_go) begin
                f_idx        <= a_idx;
                f_tag        <= a_tag;
                valid[a_idx] <= 1'b0;
                beat         <= '0;
            end
            if (state == FILL && bus.mem_ack) beat <= beat + OFF'(1);
            if (state == COMMIT) valid[f_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state == COMMIT) tag_mem[f_idx] <= f_tag;
    end

    always_ff @(posedge clk) begin
        if (!reset && state == FILL && bus.mem_ack)
            data_mem[f_idx][beat] <= bus.mem_rdata;
    end

`ifdef QM_ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (hit_c) stat_hits <= stat_hits + 32'd1;
            if (miss_go) stat_misses <= stat_misses + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_qm_icache_dm.sv
// Directed bench for qm_icache_dm: lookup table plus refill,
// wait-state, alias, reset-abort and optional counter sequences.
module tb_qm_icache_dm;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ack_wait = 1;
    int   wcnt = 0;
    logic ack_force = 1'b0;

    qm_icache_dm_if bus ();

`ifdef QM_ICACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    qm_icache_dm #(.LINES(64), .LINE_WORDS(4)) dut (
        .clk(clk),
        .reset(reset),
`ifdef QM_ICACHE_STATS_EN
        .stat_hits(stat_hits),
        .stat_misses(stat_misses),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Memory model: word = address ^ A5A5A5A5, ack after ack_wait req cycles.
    assign bus.mem_rdata = bus.mem_addr ^ 32'hA5A5A5A5;
    assign bus.mem_ack   = ack_force |
                           (bus.mem_req && wcnt == ack_wait - 1);

    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    typedef struct {
        logic        en;
        logic        ack;
        logic [31:0] addr;
        logic        hit;
        logic        stall;
        logic        req;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_until_hit(input logic [31:0] addr, output int n,
                                   output logic [31:0] first,
                                   output logic req0);
        logic seen;
        seen  = 1'b0;
        first = '0;
        req0  = 1'b0;
        n     = 0;
        bus.enable  = 1'b1;
        bus.address = addr;
        forever begin
            #1;
            if (n == 0) req0 = bus.mem_req;
            if (bus.mem_req && !seen) begin
                seen  = 1'b1;
                first = bus.mem_addr;
            end
            if (bus.hit || n >= 100) break;
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        logic [31:0] fa;
        logic r0;

        tbl[0] = '{1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 32'hA5A5A4A5};
        tbl[1] = '{1'b1, 1'b0, 32'h104, 1'b1, 1'b0, 1'b0, 32'hA5A5A4A1};
        tbl[2] = '{1'b1, 1'b0, 32'h108, 1'b1, 1'b0, 1'b0, 32'hA5A5A4AD};
        tbl[3] = '{1'b1, 1'b0, 32'h10C, 1'b1, 1'b0, 1'b0, 32'hA5A5A4A9};
        tbl[4] = '{1'b0, 1'b0, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[5] = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[6] = '{1'b1, 1'b0, 32'h108, 1'b1, 1'b0, 1'b0, 32'hA5A5A4AD};

        // Reset held with enable high
        bus.enable  = 1'b1;
        bus.address = 32'h100;
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rst_hit", {31'b0, bus.hit}, 32'd0);
            chk("rst_stall", {31'b0, bus.stall}, 32'd0);
            chk("rst_req", {31'b0, bus.mem_req}, 32'd0);
            tick();
        end
        reset = 1'b0;

        // Zero-wait refill of 0x100
        #1;
        chk("a_miss_stall", {31'b0, bus.stall}, 32'd1);
        tick();
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("a_req", {31'b0, bus.mem_req}, 32'd1);
            chk("a_addr", bus.mem_addr, 32'h100 + 32'(4 * (k - 1)));
            tick();
        end
        #1;
        chk("a_commit_req", {31'b0, bus.mem_req}, 32'd0);
        chk("a_commit_hit", {31'b0, bus.hit}, 32'd0);
        tick();
        #1;
        chk("a_hit6", {31'b0, bus.hit}, 32'd1);
        chk("a_data6", bus.data, 32'hA5A5A4A5);
        tick();

        // Lookup table on the filled line
        for (int i = 0; i < 7; i++) begin
            bus.enable  = tbl[i].en;
            bus.address = tbl[i].addr;
            ack_force   = tbl[i].ack;
            #1;
            chk($sformatf("t%0d_hit", i), {31'b0, bus.hit},
                {31'b0, tbl[i].hit});
            chk($sformatf("t%0d_stall", i), {31'b0, bus.stall},
                {31'b0, tbl[i].stall});
            chk($sformatf("t%0d_req", i), {31'b0, bus.mem_req},
                {31'b0, tbl[i].req});
            if (tbl[i].hit) chk($sformatf("t%0d_data", i), bus.data,
                                tbl[i].data);
            tick();
            ack_force = 1'b0;
        end

        // Wait-state memory, ack every third cycle
        ack_wait    = 3;
        bus.enable  = 1'b1;
        bus.address = 32'h200;
        #1;
        chk("b_miss_stall", {31'b0, bus.stall}, 32'd1);
        tick();
        for (int c = 1; c <= 12; c++) begin
            #1;
            chk("b_req", {31'b0, bus.mem_req}, 32'd1);
            chk("b_addr", bus.mem_addr, 32'h200 + 32'(4 * ((c - 1) / 3)));
            tick();
        end
        #1;
        chk("b_commit_req", {31'b0, bus.mem_req}, 32'd0);
        tick();
        #1;
        chk("b_hit14", {31'b0, bus.hit}, 32'd1);
        chk("b_data14", bus.data, 32'hA5A5A7A5);
        tick();
        ack_wait = 1;

        // Alias eviction
        fetch_until_hit(32'h1100, n, fa, r0);
        chk("alias_cycles", 32'(n), 32'd6);
        chk("alias_data", bus.data, 32'hA5A5B4A5);
        tick();
        fetch_until_hit(32'h100, n, fa, r0);
        chk("evict_cycles", 32'(n), 32'd6);
        chk("evict_first", fa, 32'h100);
        tick();

        // Reset aborting a fill after beat 2
        bus.enable  = 1'b1;
        bus.address = 32'h300;
        tick();
        for (int k = 1; k <= 3; k++) tick();
        reset = 1'b1;
        #1;
        chk("c_rst_stall", {31'b0, bus.stall}, 32'd0);
        tick();
        reset = 1'b0;
        fetch_until_hit(32'h300, n, fa, r0);
        chk("c_req_drop", {31'b0, r0}, 32'd0);
        chk("c_first", fa, 32'h300);
        chk("c_cycles", 32'(n), 32'd6);
        chk("c_data", bus.data, 32'hA5A5A6A5);
        tick();
        fetch_until_hit(32'h100, n, fa, r0);
        chk("c_valid_clr", 32'(n), 32'd6);
        tick();

`ifdef QM_ICACHE_STATS_EN
        reset      = 1'b1;
        bus.enable = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        fetch_until_hit(32'h100, n, fa, r0);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("d_hit", {31'b0, bus.hit}, 32'd1);
        end
        tick();
        bus.enable = 1'b0;
        #1;
        chk("d_hits", stat_hits, 32'd5);
        chk("d_misses", stat_misses, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
